// File: rtl/tl_ul_master_bridge_if.sv
// TL-UL channel bundle: 32-bit data bus, 8-bit source id, A channel plus D channel.
interface tl_ul_if;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        d_valid;
    logic        d_ready;

    modport master_ul (
        output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid,
        input  a_ready,
        input  d_opcode, d_size, d_source, d_data, d_error, d_valid,
        output d_ready
    );
endinterface

// File: rtl/tl_ul_master_bridge.sv
// Single-outstanding CPU load/store to TL-UL master bridge.
// Define TL_UL_MASTER_MISALIGN_CHECK_EN to error out misaligned requests locally.
module tl_ul_master_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    input  logic [7:0] byte_src,
    input  logic [7:0] half_src,
    input  logic [7:0] word_src,
    output logic       mask,
    output logic [7:0] data
);
    localparam logic [1:0] LANE_IDX = LANE[1:0];

    always_comb begin
        mask = 1'b1;
        data = word_src;
        case (size)
            2'd0: begin
                mask = (addr_lo == LANE_IDX);
                data = byte_src;
            end
            2'd1: begin
                mask = (addr_lo[1] == LANE_IDX[1]);
                data = half_src;
            end
            default: ;
        endcase
    end
endmodule

module tl_ul_master_bridge #(
    parameter logic [7:0] SOURCE_ID = 8'd0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    tl_ul_if.master_ul  tilelink
);
    localparam int         NUM_LANES      = 4;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef enum logic [1:0] {IDLE, SEND_A, WAIT_D, RESP} state_e;

    state_e      state_q, state_d;
    logic        r_write, r_signed;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;
    logic        req_fire, d_fire, d_bad;
    logic [1:0]  addr_lo_aligned;
    logic [31:0] lane_sh, load_ext;

    assign req_fire = (state_q == IDLE) && req_valid;
    assign d_fire   = (state_q == WAIT_D) && tilelink.d_valid;

    // Low address bits below the access size are dropped so lanes stay naturally aligned.
    always_comb begin
        case (req_size)
            2'd0:    addr_lo_aligned = req_addr[1:0];
            2'd1:    addr_lo_aligned = {req_addr[1], 1'b0};
            default: addr_lo_aligned = 2'b00;
        endcase
    end

`ifdef TL_UL_MASTER_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        tilelink.a_valid = 1'b0;
        tilelink.d_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
`ifdef TL_UL_MASTER_MISALIGN_CHECK_EN
                    state_d = misaligned ? RESP : SEND_A;
`else
                    state_d = SEND_A;
`endif
                end
            end
            SEND_A: begin
                tilelink.a_valid = 1'b1;
                if (tilelink.a_ready) state_d = WAIT_D;
            end
            WAIT_D: begin
                tilelink.d_ready = 1'b1;
                if (tilelink.d_valid) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_write    <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            if (req_fire) begin
                r_write  <= req_write;
                r_signed <= req_signed;
                r_size   <= req_size;
                r_addr   <= {req_addr[31:2], addr_lo_aligned};
                r_wdata  <= req_wdata;
`ifdef TL_UL_MASTER_MISALIGN_CHECK_EN
                if (misaligned) begin
                    resp_rdata <= '0;
                    resp_error <= 1'b1;
                end
`endif
            end
            if (d_fire) begin
                resp_rdata <= load_ext;
                resp_error <= d_bad;
            end
        end
    end

    logic [NUM_LANES-1:0][7:0] lane_data;
    logic [NUM_LANES-1:0]      lane_mask;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        tl_ul_master_lane #(.LANE(i)) u_lane (
            .size     (r_size),
            .addr_lo  (r_addr[1:0]),
            .byte_src (r_wdata[7:0]),
            .half_src (r_wdata[8*(i%2) +: 8]),
            .word_src (r_wdata[8*i +: 8]),
            .mask     (lane_mask[i]),
            .data     (lane_data[i])
        );
    end

    assign tilelink.a_opcode  = !r_write    ? OP_GET :
                                r_size[1]   ? OP_PUT_FULL : OP_PUT_PARTIAL;
    assign tilelink.a_param   = 3'd0;
    assign tilelink.a_size    = r_size;
    assign tilelink.a_source  = SOURCE_ID;
    assign tilelink.a_address = r_addr;
    assign tilelink.a_mask    = lane_mask;
    assign tilelink.a_data    = lane_data;

    assign d_bad = tilelink.d_error || (tilelink.d_source != SOURCE_ID) ||
                   (tilelink.d_opcode != (r_write ? OP_ACK : OP_ACK_DATA));

    // Bring the addressed lane down to bit 0, then extend by access size.
    assign lane_sh = tilelink.d_data >> {r_addr[1:0], 3'b000};

    always_comb begin
        load_ext = lane_sh;
        case (r_size)
            2'd0: load_ext = {{24{r_signed & lane_sh[7]}}, lane_sh[7:0]};
            2'd1: load_ext = {{16{r_signed & lane_sh[15]}}, lane_sh[15:0]};
            default: ;
        endcase
        if (r_write) load_ext = '0;
    end
endmodule

// File: tb/tb_tl_ul_master_bridge.sv
// Directed self-checking bench for tl_ul_master_bridge.
module tb_tl_ul_master_bridge;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_rdata;
    int          errors = 0;
    int          checks = 0;

    tl_ul_if tl();

    tl_ul_master_bridge #(.SOURCE_ID(8'd0)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .tilelink   (tl)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request at a negedge; returns one cycle later with the bridge in SEND_A.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd);
        req_write = w; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
        req_valid = 1'b1;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk_i);
        req_valid = 1'b0;
    endtask

    // Zero-wait A and D: resp_valid appears exactly 3 cycles after the fire cycle.
    task automatic run_fast(input string tag);
        chk({tag, "_a_valid"}, {31'd0, tl.a_valid}, 32'd1);
        chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_rv_c1"}, {31'd0, resp_valid}, 32'd0);
        @(negedge clk_i);
        chk({tag, "_d_ready"}, {31'd0, tl.d_ready}, 32'd1);
        chk({tag, "_rv_c2"}, {31'd0, resp_valid}, 32'd0);
        @(negedge clk_i);
        chk({tag, "_rv_c3"}, {31'd0, resp_valid}, 32'd1);
    endtask

    task automatic ack_resp(input string tag);
        resp_ready = 1'b1;
        @(negedge clk_i);
        resp_ready = 1'b0;
        chk({tag, "_rv_drop"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        reset_i = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        tl.a_ready = 1'b1; tl.d_valid = 1'b1; tl.d_opcode = 3'd1; tl.d_size = 2'd2;
        tl.d_source = 8'd0; tl.d_data = 32'hDEADBEEF; tl.d_error = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_a_valid", {31'd0, tl.a_valid}, 32'd0);
        chk("rst_d_ready", {31'd0, tl.d_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);

        // Word load, both channels ready
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        chk("lw_opcode", {29'd0, tl.a_opcode}, 32'd4);
        chk("lw_mask", {28'd0, tl.a_mask}, 32'hF);
        chk("lw_addr", tl.a_address, 32'h100);
        chk("lw_size", {30'd0, tl.a_size}, 32'd2);
        chk("lw_source", {24'd0, tl.a_source}, 32'd0);
        chk("lw_param", {29'd0, tl.a_param}, 32'd0);
        run_fast("lw");
        chk("lw_rdata", resp_rdata, 32'hDEADBEEF);
        chk("lw_err", {31'd0, resp_error}, 32'd0);
        ack_resp("lw");

        // Signed then unsigned byte load from the top lane
        tl.d_data = 32'h80000000;
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        chk("lbs_mask", {28'd0, tl.a_mask}, 32'h8);
        chk("lbs_addr", tl.a_address, 32'h103);
        run_fast("lbs");
        chk("lbs_rdata", resp_rdata, 32'hFFFFFF80);
        ack_resp("lbs");
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        run_fast("lbu");
        chk("lbu_rdata", resp_rdata, 32'h00000080);
        ack_resp("lbu");

        // Signed half load from upper half
        tl.d_data = 32'h8001ABCD;
        issue(1'b0, 2'd1, 1'b1, 32'h202, 32'h0);
        chk("lhs_mask", {28'd0, tl.a_mask}, 32'hC);
        run_fast("lhs");
        chk("lhs_rdata", resp_rdata, 32'hFFFF8001);
        ack_resp("lhs");

        // Half store with A back-pressure for 3 cycles
        tl.a_ready = 1'b0; tl.d_opcode = 3'd0;
        issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) tl.a_ready = 1'b1;
            chk("sh_a_valid", {31'd0, tl.a_valid}, 32'd1);
            chk("sh_opcode", {29'd0, tl.a_opcode}, 32'd1);
            chk("sh_mask", {28'd0, tl.a_mask}, 32'hC);
            chk("sh_data", tl.a_data, 32'h12341234);
            chk("sh_addr", tl.a_address, 32'h102);
            if (c < 3) @(negedge clk_i);
        end
        @(negedge clk_i);
        chk("sh_d_ready", {31'd0, tl.d_ready}, 32'd1);
        @(negedge clk_i);
        chk("sh_rv", {31'd0, resp_valid}, 32'd1);
        chk("sh_err", {31'd0, resp_error}, 32'd0);
        chk("sh_rdata", resp_rdata, 32'd0);
        ack_resp("sh");

        // Byte store and word store data replication / opcodes
        issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h000000A5);
        chk("sb_opcode", {29'd0, tl.a_opcode}, 32'd1);
        chk("sb_mask", {28'd0, tl.a_mask}, 32'h2);
        chk("sb_data", tl.a_data, 32'hA5A5A5A5);
        run_fast("sb");
        ack_resp("sb");
        issue(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D);
        chk("sw_opcode", {29'd0, tl.a_opcode}, 32'd0);
        chk("sw_data", tl.a_data, 32'hCAFEF00D);
        run_fast("sw");
        chk("sw_err", {31'd0, resp_error}, 32'd0);
        ack_resp("sw");

        // Wrong source: error, response held while resp_ready low
        tl.d_opcode = 3'd1; tl.d_source = 8'd5; tl.d_data = 32'h11223344;
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        run_fast("src");
        tl.d_data = 32'h0;
        for (int c = 0; c < 2; c++) begin
            chk("src_rv_hold", {31'd0, resp_valid}, 32'd1);
            chk("src_err", {31'd0, resp_error}, 32'd1);
            chk("src_rdata_hold", resp_rdata, 32'h11223344);
            chk("src_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk_i);
        end
        ack_resp("src");

        // d_error set, then opcode mismatch (AccessAckData answering a store)
        tl.d_source = 8'd0; tl.d_error = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        run_fast("derr");
        chk("derr_err", {31'd0, resp_error}, 32'd1);
        ack_resp("derr");
        tl.d_error = 1'b0;
        issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h1);
        run_fast("dop");
        chk("dop_err", {31'd0, resp_error}, 32'd1);
        ack_resp("dop");

        // Misaligned word load
        tl.d_data = 32'h55667788;
        issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
`ifdef TL_UL_MASTER_MISALIGN_CHECK_EN
        chk("mis_a_valid", {31'd0, tl.a_valid}, 32'd0);
        chk("mis_rv", {31'd0, resp_valid}, 32'd1);
        chk("mis_err", {31'd0, resp_error}, 32'd1);
        chk("mis_rdata", resp_rdata, 32'd0);
`else
        chk("mis_addr", tl.a_address, 32'h100);
        chk("mis_mask", {28'd0, tl.a_mask}, 32'hF);
        run_fast("mis");
        chk("mis_rdata", resp_rdata, 32'h55667788);
        chk("mis_err", {31'd0, resp_error}, 32'd0);
`endif
        ack_resp("mis");

        // Reset while waiting on D abandons the transaction
        tl.d_valid = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        @(negedge clk_i);
        chk("rw_d_ready", {31'd0, tl.d_ready}, 32'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("rw_d_ready_rst", {31'd0, tl.d_ready}, 32'd0);
        chk("rw_a_valid_rst", {31'd0, tl.a_valid}, 32'd0);
        chk("rw_rv_rst", {31'd0, resp_valid}, 32'd0);
        chk("rw_rdata_rst", resp_rdata, 32'd0);
        chk("rw_err_rst", {31'd0, resp_error}, 32'd0);
        tl.d_valid = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk("rw_no_resp", {31'd0, resp_valid}, 32'd0);
            chk("rw_idle", {31'd0, req_ready}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
